// File: rtl/patdet_pkg.sv
// rtl/patdet_pkg.sv - shared state enum, reset defaults and width helper for patdet_prog
package patdet_pkg;

    typedef enum logic [1:0] {
        DIS   = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int         PD_MAX_LEN     = 8;
    localparam logic [7:0] PD_DEF_PAT     = 8'b0001_0010;
    localparam int         PD_DEF_LEN     = 5;
    localparam bit         PD_DEF_OVERLAP = 1'b0;
    localparam int         PD_CNT_W       = 16;

    // Width able to hold every length 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/patdet_hist.sv
// rtl/patdet_hist.sv - serial history shift register with saturating fill counter
module patdet_hist #(
    parameter int MAX_LEN = 8,
    parameter int LW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               restart,
    input  logic               in,
    output logic [MAX_LEN-1:0] hist,
    output logic [LW-1:0]      fill
);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= {hist[MAX_LEN-2:0], in};
            // restart marks a non-overlapping match: the shifted bits no longer count
            if (restart)
                fill <= '0;
            else if (fill != LW'(MAX_LEN))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/patdet_prog.sv
// rtl/patdet_prog.sv - runtime-programmable serial pattern detector (optional PATDET_MATCH_CNT_EN match counter)
module patdet_prog
    import patdet_pkg::*;
#(
    parameter int                 MAX_LEN     = PD_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PAT     = MAX_LEN'(PD_DEF_PAT),
    parameter int                 DEF_LEN     = PD_DEF_LEN,
    parameter bit                 DEF_OVERLAP = PD_DEF_OVERLAP,
`ifdef PATDET_MATCH_CNT_EN
    parameter int                 CNT_W       = PD_CNT_W,
`endif
    localparam int                LW          = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LW-1:0]      pat_len,
    input  logic               overlap,
    output logic               out,
    output logic               cfg_err
`ifdef PATDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    logic [MAX_LEN-1:0] cur_pat;
    logic [LW-1:0]      cur_len;
    logic               cur_ovl;
    state_t             state;
    state_t             state_nxt;

    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN:0]   mask;
    logic [MAX_LEN:0]   window;
    logic [MAX_LEN:0]   ref_pat;
    logic [LW:0]        fill_p1;
    logic               len_ok;
    logic               shift;
    logic               match;
    logic               restart;

    patdet_hist #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .clr     (cfg_load),
        .shift   (shift),
        .restart (restart),
        .in      (in),
        .hist    (hist),
        .fill    (fill)
    );

    // Compare over MAX_LEN+1 bits so the incoming bit and the full history line up
    always_comb begin
        mask = '0;
        for (int i = 0; i <= MAX_LEN; i++)
            mask[i] = (i < int'(cur_len));
    end

    always_comb begin
        window  = {hist, in} & mask;
        ref_pat = {1'b0, cur_pat} & mask;
        fill_p1 = {1'b0, fill} + 1'b1;
        len_ok  = (pat_len != '0) && ({1'b0, pat_len} <= (LW+1)'(MAX_LEN));
        shift   = valid && !cfg_load && (state != DIS);
        match   = shift && (fill_p1 >= {1'b0, cur_len}) && (window == ref_pat);
        restart = match && !cur_ovl;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = len_ok ? FILL : DIS;
        end else begin
            case (state)
                DIS:   state_nxt = DIS;
                FILL: begin
                    if (match)
                        state_nxt = cur_ovl ? ARMED : FILL;
                    else if (shift && ((fill_p1 + 1'b1) >= {1'b0, cur_len}))
                        state_nxt = ARMED;
                end
                ARMED: begin
                    if (match && !cur_ovl)
                        state_nxt = FILL;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_pat <= DEF_PAT;
            cur_len <= LW'(DEF_LEN);
            cur_ovl <= DEF_OVERLAP;
            state   <= FILL;
            out     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= match;
            if (cfg_load) begin
                cfg_err <= !len_ok;
                // A rejected load keeps the previous config; DIS blocks it anyway
                if (len_ok) begin
                    cur_pat <= pat;
                    cur_len <= pat_len;
                    cur_ovl <= overlap;
                end
            end
        end
    end

`ifdef PATDET_MATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst || cfg_load)
            match_cnt <= '0;
        else if (match && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
    end
`endif

endmodule
